// File: rtl/if_id_queue.sv
// Instruction fetch queue between IF and ID: a DEPTH-entry FIFO of {PCNext, instruction}
// pairs with valid/ready handshakes on both sides, flushed whole on a taken branch.
module if_id_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_IF_valid,
  input  logic [31:0]       i_IF_data_PCNext,
  input  logic [31:0]       i_IF_data_instruction,
  output logic              o_IF_ready,
  input  logic              i_IF_ctrl_PCSrc,
  output logic              o_ID_valid,
  output logic [31:0]       o_ID_data_instruction,
  output logic [31:0]       o_ID_data_PCNext,
  input  logic              i_ID_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [63:0]       storage_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              push, pop;

  assign o_IF_ready = (count_q != FULL_CNT);
  assign o_ID_valid = (count_q != '0);
  assign o_count    = count_q;
  assign o_err      = err_q;

  assign push = i_IF_valid & o_IF_ready & ~i_IF_ctrl_PCSrc;
  assign pop  = o_ID_valid & i_ID_ready & ~i_IF_ctrl_PCSrc;

  always_comb begin
    o_ID_data_instruction = NOP_INSTR;
    o_ID_data_PCNext      = '0;
    if (o_ID_valid) begin
      o_ID_data_PCNext      = storage_q[rd_ptr_q][63:32];
      o_ID_data_instruction = storage_q[rd_ptr_q][31:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (i_IF_ctrl_PCSrc) begin
      // Flush outranks both handshakes; storage is left as-is, only pointers reset.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_IF_valid && !o_IF_ready) err_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) storage_q[wr_ptr_q] <= {i_IF_data_PCNext, i_IF_data_instruction};
    end
  end

endmodule
